// File: rtl/req_arbiter8.sv
// Round-robin arbiter sharing one 8-input encoder among 8 requesters; grant held until the owner drops req.
// Optional ARB_TIMEOUT_EN: forced release after MAX_HOLD busy cycles, tmo pulse, owner masked until it drops req.
//   state  | meaning
//   S_IDLE | no owner; eligible requests arbitrated on the next edge
//   S_BUSY | gnt_idx owns the encoder until it drops req (or times out)
module req_arbiter8 #(
    parameter int PTR_INIT = 0,
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       tmo
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_BUSY = 1'b1;
    localparam logic [2:0] PTR_RST = 3'(PTR_INIT);

    if (PTR_INIT < 0 || PTR_INIT > 7 || MAX_HOLD < 1) begin : g_param_check
        $error("req_arbiter8: PTR_INIT must be 0..7 and MAX_HOLD must be >= 1");
    end

    logic       r_state;
    logic [7:0] r_gnt;
    logic [2:0] r_gnt_idx;
    logic       r_gnt_valid;
    logic [2:0] r_ptr;

    logic [7:0] w_elig;
    logic       w_found;
    logic [2:0] w_win;
    logic       w_own_req;

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    logic [7:0]        r_mask;
    logic [HOLD_W-1:0] r_hold;
    logic              r_tmo;

    assign w_elig = req & ~r_mask;
    assign tmo    = r_tmo;
`else
    assign w_elig = req;
    assign tmo    = 1'b0;
`endif

    assign w_own_req = req[r_gnt_idx];
    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;

    // First eligible index at or after the pointer, wrapping modulo 8.
    always_comb begin
        logic [2:0] w_cand;
        w_found = 1'b0;
        w_win   = 3'd0;
        w_cand  = 3'd0;
        for (int k = 0; k < 8; k++) begin
            w_cand = r_ptr + 3'(k);
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_gnt       <= 8'h00;
            r_gnt_idx   <= 3'd0;
            r_gnt_valid <= 1'b0;
            r_ptr       <= PTR_RST;
`ifdef ARB_TIMEOUT_EN
            r_mask      <= 8'h00;
            r_hold      <= '0;
            r_tmo       <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            r_tmo  <= 1'b0;
            r_mask <= r_mask & req;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt       <= 8'h01 << w_win;
                        r_gnt_idx   <= w_win;
                        r_gnt_valid <= 1'b1;
                        r_ptr       <= w_win + 3'd1;
                        r_state     <= S_BUSY;
`ifdef ARB_TIMEOUT_EN
                        r_hold      <= HOLD_W'(1);
`endif
                    end
                end
                default: begin
                    if (!w_own_req) begin
                        r_gnt       <= 8'h00;
                        r_gnt_idx   <= 3'd0;
                        r_gnt_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
`ifdef ARB_TIMEOUT_EN
                    // Owner kept req high for its full allowance: force release and mask it.
                    else if (r_hold == HOLD_MAX) begin
                        r_gnt              <= 8'h00;
                        r_gnt_idx          <= 3'd0;
                        r_gnt_valid        <= 1'b0;
                        r_state            <= S_IDLE;
                        r_tmo              <= 1'b1;
                        r_mask[r_gnt_idx]  <= 1'b1;
                    end else if (r_hold != '1) begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_arbiter8.sv
// Self-checking bench for req_arbiter8 (PTR_INIT=0, MAX_HOLD=4); follows ARB_TIMEOUT_EN like the RTL.
module tb_req_arbiter8;

    localparam int PTR_INIT = 0;
    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       tmo;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic       tmo;
    } obs_t;

    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;

    req_arbiter8 #(.PTR_INIT(PTR_INIT), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .tmo       (tmo)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic v, input logic [2:0] i, input logic t);
        obs_t e;
        e.gnt = v ? (8'h01 << i) : 8'h00;
        e.idx = v ? i : 3'd0;
        e.vld = v;
        e.tmo = t;
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.gnt = gnt;
        o.idx = gnt_idx;
        o.vld = gnt_valid;
        o.tmo = tmo;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, got;
        req = 8'h00;
        #12;
        sb.push_back(mk(1'b0, 3'd0, 1'b0));
        e = sb.pop_front(); got = observe(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset_held: got gnt=%h idx=%0d vld=%b tmo=%b, expected gnt=%h idx=%0d vld=%b tmo=%b",
                     got.gnt, got.idx, got.vld, got.tmo, e.gnt, e.idx, e.vld, e.tmo);
        end
        #8 rst_n = 1'b1;
        sb.push_back(mk(1'b0, 3'd0, 1'b0));
        tick();
        e = sb.pop_front(); got = observe(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset_idle: got gnt=%h idx=%0d vld=%b tmo=%b, expected gnt=%h idx=%0d vld=%b tmo=%b",
                     got.gnt, got.idx, got.vld, got.tmo, e.gnt, e.idx, e.vld, e.tmo);
        end
    endtask

    task automatic test_single();
        logic [7:0] stim[$];
        obs_t       want[$];
        obs_t       e, got;
        stim = '{8'h01, 8'h00, 8'h00};
        want = '{mk(1'b1, 3'd0, 1'b0), mk(1'b0, 3'd0, 1'b0), mk(1'b0, 3'd0, 1'b0)};
        for (int s = 0; s < stim.size(); s++) begin
            req = stim[s];
            sb.push_back(want[s]);
            tick();
            e = sb.pop_front(); got = observe(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL single[%0d]: got gnt=%h idx=%0d vld=%b tmo=%b, expected gnt=%h idx=%0d vld=%b tmo=%b",
                         s, got.gnt, got.idx, got.vld, got.tmo, e.gnt, e.idx, e.vld, e.tmo);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] stim[$];
        obs_t       want[$];
        obs_t       e, got;
        // Pointer back to PTR_INIT so the sequence starts at 0.
        #3 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            stim.push_back(8'hFF);
            want.push_back(mk(1'b1, 3'(i), 1'b0));
            stim.push_back(8'hFF & ~(8'h01 << i));
            want.push_back(mk(1'b0, 3'd0, 1'b0));
        end
        stim.push_back(8'hFF); want.push_back(mk(1'b1, 3'd0, 1'b0));
        stim.push_back(8'hFE); want.push_back(mk(1'b0, 3'd0, 1'b0));
        for (int s = 0; s < stim.size(); s++) begin
            req = stim[s];
            sb.push_back(want[s]);
            tick();
            e = sb.pop_front(); got = observe(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL round_robin[%0d]: got gnt=%h idx=%0d vld=%b tmo=%b, expected gnt=%h idx=%0d vld=%b tmo=%b",
                         s, got.gnt, got.idx, got.vld, got.tmo, e.gnt, e.idx, e.vld, e.tmo);
            end
        end
    endtask

    task automatic test_contention();
        logic [7:0] stim[$];
        obs_t       want[$];
        obs_t       e, got;
        // Pointer is 1 here; granting idx 2 moves it to 3.
        stim = '{8'h04, 8'h00, 8'h84, 8'hA4, 8'hA4, 8'h24, 8'h24, 8'h20, 8'h20, 8'h02, 8'h02, 8'h00};
        want = '{mk(1'b1, 3'd2, 1'b0), mk(1'b0, 3'd0, 1'b0),
                 mk(1'b1, 3'd7, 1'b0), mk(1'b1, 3'd7, 1'b0), mk(1'b1, 3'd7, 1'b0),
                 mk(1'b0, 3'd0, 1'b0), mk(1'b1, 3'd2, 1'b0),
                 mk(1'b0, 3'd0, 1'b0), mk(1'b1, 3'd5, 1'b0),
                 mk(1'b0, 3'd0, 1'b0), mk(1'b1, 3'd1, 1'b0),
                 mk(1'b0, 3'd0, 1'b0)};
        for (int s = 0; s < stim.size(); s++) begin
            req = stim[s];
            sb.push_back(want[s]);
            tick();
            e = sb.pop_front(); got = observe(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL contention[%0d]: got gnt=%h idx=%0d vld=%b tmo=%b, expected gnt=%h idx=%0d vld=%b tmo=%b",
                         s, got.gnt, got.idx, got.vld, got.tmo, e.gnt, e.idx, e.vld, e.tmo);
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] stim[$];
        obs_t       want[$];
        obs_t       e, got;
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < MAX_HOLD; c++) begin
            stim.push_back(8'h02); want.push_back(mk(1'b1, 3'd1, 1'b0));
        end
        stim.push_back(8'h02); want.push_back(mk(1'b0, 3'd0, 1'b1));
        stim.push_back(8'h02); want.push_back(mk(1'b0, 3'd0, 1'b0));
        stim.push_back(8'h02); want.push_back(mk(1'b0, 3'd0, 1'b0));
        stim.push_back(8'h00); want.push_back(mk(1'b0, 3'd0, 1'b0));
        stim.push_back(8'h02); want.push_back(mk(1'b1, 3'd1, 1'b0));
        stim.push_back(8'h00); want.push_back(mk(1'b0, 3'd0, 1'b0));
`else
        for (int c = 0; c < 120; c++) begin
            stim.push_back(8'h02); want.push_back(mk(1'b1, 3'd1, 1'b0));
        end
        stim.push_back(8'h00); want.push_back(mk(1'b0, 3'd0, 1'b0));
`endif
        for (int s = 0; s < stim.size(); s++) begin
            req = stim[s];
            sb.push_back(want[s]);
            tick();
            e = sb.pop_front(); got = observe(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL timeout[%0d]: got gnt=%h idx=%0d vld=%b tmo=%b, expected gnt=%h idx=%0d vld=%b tmo=%b",
                         s, got.gnt, got.idx, got.vld, got.tmo, e.gnt, e.idx, e.vld, e.tmo);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        obs_t e, got;
        // Pointer is 2 here, so req=FF is granted idx 2 first.
        req = 8'hFF;
        sb.push_back(mk(1'b1, 3'd2, 1'b0));
        tick();
        e = sb.pop_front(); got = observe(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL mid_busy_grant: got gnt=%h idx=%0d vld=%b tmo=%b, expected gnt=%h idx=%0d vld=%b tmo=%b",
                     got.gnt, got.idx, got.vld, got.tmo, e.gnt, e.idx, e.vld, e.tmo);
        end
        #2 rst_n = 1'b0;
        sb.push_back(mk(1'b0, 3'd0, 1'b0));
        #1;
        e = sb.pop_front(); got = observe(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL mid_busy_async: got gnt=%h idx=%0d vld=%b tmo=%b, expected gnt=%h idx=%0d vld=%b tmo=%b",
                     got.gnt, got.idx, got.vld, got.tmo, e.gnt, e.idx, e.vld, e.tmo);
        end
        #2 rst_n = 1'b1;
        sb.push_back(mk(1'b1, 3'(PTR_INIT), 1'b0));
        tick();
        e = sb.pop_front(); got = observe(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL mid_busy_ptr_init: got gnt=%h idx=%0d vld=%b tmo=%b, expected gnt=%h idx=%0d vld=%b tmo=%b",
                     got.gnt, got.idx, got.vld, got.tmo, e.gnt, e.idx, e.vld, e.tmo);
        end
        req = 8'hFF & ~(8'h01 << PTR_INIT);
        sb.push_back(mk(1'b0, 3'd0, 1'b0));
        tick();
        e = sb.pop_front(); got = observe(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL mid_busy_release: got gnt=%h idx=%0d vld=%b tmo=%b, expected gnt=%h idx=%0d vld=%b tmo=%b",
                     got.gnt, got.idx, got.vld, got.tmo, e.gnt, e.idx, e.vld, e.tmo);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_contention();
        test_timeout();
        test_reset_mid_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
